// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared FSM state codes and handshake levels for the sequential divider
package div_seq_pkg;
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;
  localparam logic DIV_RESULT_READY = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START = 1'b1;
endpackage

// File: rtl/div_seq_step.sv
// div_step: one combinational radix-2 restoring iteration on the packed {rem, quot} word
module div_step
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] work_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [2*WIDTH:0] work_o
);
  logic [WIDTH+1:0] trial;
  // shifted remainder minus divisor; the sign bit picks restore vs. keep
  always_comb begin
    trial = work_i[2*WIDTH:WIDTH-1] - {2'b00, divisor_i};
    work_o = trial[WIDTH+1] ? {work_i[2*WIDTH-1:0], 1'b0}
                            : {trial[WIDTH:0], work_i[WIDTH-2:0], 1'b1};
  end
endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle DIV/DIVU sequencer (Free/ByZero/On/End); DIV_ZERO_SKIP_EN short-circuits a zero dividend
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);
  div_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH:0] work_q, work_d, step;
  logic [WIDTH-1:0] dvsr_q, dvsr_d, a_abs, b_abs, quot, rem;
  logic sdiv_q, sdiv_d, s1_q, s1_d, s2_q, s2_d, go, zero_in;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic ready_q, ready_d;
  div_step #(.WIDTH(WIDTH)) u_step (
    .work_i(work_q),
    .divisor_i(dvsr_q),
    .work_o(step)
  );
  assign go = start_i == DIV_START && !annul_i;
`ifdef DIV_ZERO_SKIP_EN
  assign zero_in = opdata2_i == '0 || opdata1_i == '0;
`else
  assign zero_in = opdata2_i == '0;
`endif
  assign a_abs = signed_div_i && opdata1_i[WIDTH-1] ? -opdata1_i : opdata1_i;
  assign b_abs = signed_div_i && opdata2_i[WIDTH-1] ? -opdata2_i : opdata2_i;
  assign quot = sdiv_q && (s1_q ^ s2_q) ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
  assign rem = sdiv_q && s1_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
  assign result_o = result_q;
  assign ready_o = ready_q;
  assign busy_o = state_q != DIV_FREE;
  // next-state, iteration and result-register logic
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    work_d = work_q;
    dvsr_d = dvsr_q;
    sdiv_d = sdiv_q;
    s1_d = s1_q;
    s2_d = s2_q;
    result_d = result_q;
    ready_d = ready_q;
    case (state_q)
      DIV_FREE: begin
        result_d = '0;
        ready_d = DIV_RESULT_NOT_READY;
        if (go && zero_in) state_d = DIV_BY_ZERO;
        else if (go) begin
          state_d = DIV_ON;
          cnt_d = '0;
          work_d = {{(WIDTH+1){1'b0}}, a_abs};
          dvsr_d = b_abs;
          sdiv_d = signed_div_i;
          s1_d = opdata1_i[WIDTH-1];
          s2_d = opdata2_i[WIDTH-1];
        end
      end
      DIV_BY_ZERO: begin
        state_d = DIV_END;
        result_d = '0;
        ready_d = DIV_RESULT_READY;
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_FREE;
          result_d = '0;
          ready_d = DIV_RESULT_NOT_READY;
        end else if (cnt_q != CNT_W'(WIDTH)) begin
          work_d = step;
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = DIV_END;
          result_d = {rem, quot};
          ready_d = DIV_RESULT_READY;
        end
      end
      DIV_END: begin
        if (annul_i || start_i != DIV_START) begin
          state_d = DIV_FREE;
          result_d = '0;
          ready_d = DIV_RESULT_NOT_READY;
        end
      end
    endcase
  end
  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_FREE;
      cnt_q <= '0;
      work_q <= '0;
      dvsr_q <= '0;
      sdiv_q <= 1'b0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      result_q <= '0;
      ready_q <= DIV_RESULT_NOT_READY;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      work_q <= work_d;
      dvsr_q <= dvsr_d;
      sdiv_q <= sdiv_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      result_q <= result_d;
      ready_q <= ready_d;
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed plus random DIV/DIVU checks against an arithmetic reference model
module tb_div_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic start_i = 1'b0;
  logic annul_i = 1'b0;
  logic [63:0] result_o;
  logic ready_o;
  logic busy_o;
  int tests = 0;
  int fails = 0;

  div_seq dut (
    .clk(clk),
    .rst(rst),
    .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i),
    .start_i(start_i),
    .annul_i(annul_i),
    .result_o(result_o),
    .ready_o(ready_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    if (b == 0) return 64'h0;
    x = sd ? longint'($signed(a)) : longint'({32'h0, a});
    y = sd ? longint'($signed(b)) : longint'({32'h0, b});
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_div(input string tag, input logic sd, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int edges;
    int want;
    exp = model(sd, a, b);
`ifdef DIV_ZERO_SKIP_EN
    want = (b == 0 || a == 0) ? 1 : 33;
`else
    want = (b == 0) ? 1 : 33;
`endif
    signed_div_i = sd;
    opdata1_i = a;
    opdata2_i = b;
    start_i = 1'b1;
    edges = -1;
    do begin
      tick();
      edges++;
    end while (!ready_o && edges < 60);
    chk({tag, "_latency"}, 66'(edges), 66'(want));
    chk({tag, "_result"}, 66'(result_o), 66'(exp));
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    signed_div_i = ~sd;
    repeat (2) tick();
    chk({tag, "_hold"}, {ready_o, busy_o, result_o}, {1'b1, 1'b1, exp});
    start_i = 1'b0;
    tick();
    chk({tag, "_release"}, {ready_o, busy_o, result_o}, 66'h0);
  endtask

  initial begin
    logic saw;
    logic sd;
    logic [31:0] a, b;
    repeat (2) tick();
    chk("reset", {ready_o, busy_o, result_o}, 66'h0);
    rst = 1'b0;
    tick();
    do_div("divu_100_7", 1'b0, 32'd100, 32'd7);
    do_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'h2);
    do_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF);
    do_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'h1);
    do_div("div_by_zero", 1'b0, 32'd1234, 32'h0);
    do_div("zero_dividend", 1'b1, 32'h0, 32'd5);
    signed_div_i = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    saw = 1'b0;
    repeat (11) begin
      tick();
      saw |= ready_o;
    end
    chk("annul_busy", 66'(busy_o), 66'h1);
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    chk("annul_free", {saw, ready_o, busy_o, result_o[62:0]}, 66'h0);
    do_div("after_annul_9_3", 1'b0, 32'd9, 32'd3);
    opdata1_i = 32'd77;
    opdata2_i = 32'd5;
    start_i = 1'b1;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    chk("reset_mid_on", {ready_o, busy_o, result_o}, 66'h0);
    rst = 1'b0;
    start_i = 1'b0;
    tick();
    start_i = 1'b1;
    annul_i = 1'b1;
    tick();
    chk("start_annul_free", {ready_o, busy_o, result_o}, 66'h0);
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();
    for (int i = 0; i < 24; i++) begin
      sd = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: a = 32'h0;
        1: a = 32'h80000000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = $urandom_range(1, 20);
        2: b = 32'hFFFFFFFF;
        3: b = 32'h80000000;
        default: b = $urandom;
      endcase
      do_div("random", sd, a, b);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
